// File: rtl/digit_serial_addsub_if.sv
// digit_serial_addsub_if: operand and result handshake bundle for digit_serial_addsub.
interface digit_serial_addsub_if #(parameter int WIDTH = 16);
    logic in_valid, in_ready, cin, sub;
    logic out_valid, out_ready, cout, ovf, busy;
    logic [WIDTH-1:0] a, b, sum;
    modport master(
        output in_valid, a, b, cin, sub, out_ready,
        input in_ready, out_valid, sum, cout, ovf, busy
    );
    modport slave(
        input in_valid, a, b, cin, sub, out_ready,
        output in_ready, out_valid, sum, cout, ovf, busy
    );
endinterface

// File: rtl/digit_serial_addsub.sv
// digit_serial_addsub: digit-serial adder/subtractor reusing one DIGIT-wide adder over NDIG cycles.
module digit_serial_addsub #(
    parameter int WIDTH = 16,
    parameter int DIGIT = 4
) (
    input logic clk,
    input logic rst,
    digit_serial_addsub_if.slave bus
);
    localparam int NDIG = WIDTH / DIGIT;
    localparam int CW = NDIG > 1 ? $clog2(NDIG) : 1;
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    state_t state, state_nx;
    logic [CW-1:0] cnt;
    logic [WIDTH-1:0] opa, opb, acc;
    logic carry, cout_q, ovf_q, last;
    logic [DIGIT:0] dsum;
    logic [WIDTH+DIGIT-1:0] sh;
    assign last = cnt == CW'(NDIG - 1);
    assign dsum = {1'b0, opa[DIGIT-1:0]} + {1'b0, opb[DIGIT-1:0]} + {{DIGIT{1'b0}}, carry};
    assign sh = {dsum[DIGIT-1:0], acc};
    assign bus.in_ready = state == IDLE;
    assign bus.out_valid = state == DONE;
    assign bus.busy = state != IDLE;
    assign bus.sum = acc;
    assign bus.cout = cout_q;
    assign bus.ovf = ovf_q;
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else state <= state_nx;
    end
    always_comb begin
        state_nx = state;
        case (state)
            IDLE: if (bus.in_valid) state_nx = RUN;
            RUN: if (last) state_nx = DONE;
            DONE: if (bus.out_ready) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end
    // Subtraction is a + ~b + ~cin, so the inversion happens once at accept.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
            opa <= '0;
            opb <= '0;
            acc <= '0;
            carry <= 1'b0;
            cout_q <= 1'b0;
            ovf_q <= 1'b0;
        end else if (state == IDLE && bus.in_valid) begin
            opa <= bus.a;
            opb <= bus.sub ? ~bus.b : bus.b;
            carry <= bus.cin ^ bus.sub;
            cnt <= '0;
        end else if (state == RUN) begin
            acc <= sh[WIDTH+DIGIT-1:DIGIT];
            opa <= opa >> DIGIT;
            opb <= opb >> DIGIT;
            carry <= dsum[DIGIT];
            cnt <= cnt + 1'b1;
            if (last) begin
                cout_q <= dsum[DIGIT];
                // carry into the MSB is recovered from its sum bit and operands
                ovf_q <= dsum[DIGIT] ^ dsum[DIGIT-1] ^ opa[DIGIT-1] ^ opb[DIGIT-1];
            end
        end
    end
endmodule

// File: doc/digit_serial_addsub.md
# digit_serial_addsub

Parametrised digit-serial adder/subtractor. It processes DIGIT bits per clock through a registered carry, so one narrow full-adder chain is reused across a WIDTH-bit operand. Operands are accepted and results returned over valid/ready handshakes. It is the area-optimised arithmetic unit for datapaths where multi-cycle latency is acceptable.

## Interface
Parameters:
- WIDTH, 16, operand and result width in bits.
- DIGIT, 4, bits processed per cycle. Legal range is 1 ≤ DIGIT ≤ WIDTH, with WIDTH % DIGIT == 0. NDIG = WIDTH/DIGIT.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  operand request.
- in_ready  output  1  block can accept operands (IDLE only).
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- cin  input  1  carry-in (add) or borrow-in (sub).
- sub  input  1  0: a+b+cin; 1: a−b−cin.
- out_valid  output  1  result available.
- out_ready  input  1  consumer accepts the result.
- sum  output  WIDTH  result, modulo 2^WIDTH.
- cout  output  1  raw carry out of the MSB. In sub mode, 1 means no borrow.
- ovf  output  1  two's-complement signed overflow.
- busy  output  1  high in RUN and DONE.

## Operation
- State machine with three states: IDLE, RUN, DONE.
- Reset: the state goes to IDLE. Digit counter, operand, sum, cout, ovf and carry registers all go to 0.
  - After reset, in_ready=1, out_valid=0, busy=0.
  - rst dominates every other input in every state. A reset during RUN or DONE discards the operation with no output.
- IDLE: in_ready=1. When in_valid && in_ready is sampled at an edge, the block:
  - latches A=a;
  - latches B=b if sub=0, or B=~b if sub=1;
  - sets carry = cin if sub=0, or carry = ~cin if sub=1;
  - clears the counter and goes to RUN.
  - Net effect: sub=1 computes a + ~b + ~cin = a − b − cin.
- RUN: in_ready=0, and in_valid is ignored. At each edge the block:
  - adds A[DIGIT-1:0] + B[DIGIT-1:0] + carry as a DIGIT-bit ripple chain of full-adder cells;
  - shifts the DIGIT result bits into the sum register from the top (right shift by DIGIT);
  - right-shifts A and B by DIGIT;
  - stores the digit carry-out into carry and increments the counter.
  - On the edge that processes digit NDIG−1:
    - cout ← final carry-out;
    - ovf ← (carry into bit WIDTH−1) XOR (carry out of bit WIDTH−1), taken from inside the last digit's chain;
    - the state goes to DONE.
- DONE: out_valid=1. sum, cout and ovf are stable and held while out_ready=0.
  - When out_valid && out_ready is sampled at an edge, the state goes to IDLE.
  - There is no accept-while-done overlap: in_ready stays 0 in DONE.
- sum, cout and ovf hold their last values outside DONE. They are meaningful only while out_valid=1.
- Width rules:
  - Counter width is clog2(NDIG), minimum 1 bit.
  - DIGIT=WIDTH (NDIG=1) is a single RUN cycle.
  - DIGIT=1 is fully bit-serial.

## Timing
- Let T0 be the accept edge. Digit k is processed at edge T0+1+k.
- out_valid is first high in the cycle after edge T0+NDIG, so latency is NDIG cycles from acceptance to out_valid.
- With out_ready held high, the result handshake occurs at edge T0+NDIG+1. in_ready is high after that edge, so the next accept is at T0+NDIG+2 at the earliest.
- Peak throughput is one operation per NDIG+2 cycles.
- No combinational path from any input to any output. All outputs are registered or decoded from the state.

## Test plan
- WIDTH=16, DIGIT=4, add: 0x1234+0x4321, cin=0 → sum=0x5555, cout=0, ovf=0. out_valid rises exactly 4 edges after the accept edge.
- Add boundaries:
  - 0xFFFF+0x0001 → sum=0x0000, cout=1, ovf=0.
  - 0x7FFF+0x0001 → sum=0x8000, cout=0, ovf=1.
  - 0xFFFF+0xFFFF, cin=1 → sum=0xFFFF, cout=1, ovf=0.
- Subtract:
  - 0x0005−0x0007, cin=0 → sum=0xFFFE, cout=0, ovf=0.
  - 0x8000−0x0001 → sum=0x7FFF, cout=1, ovf=1.
  - 0x0010−0x0003, cin=1 → sum=0x000C, cout=1.
- Backpressure:
  - Hold out_ready=0 for 5 cycles in DONE. sum, cout, ovf and out_valid stay constant, in_ready=0, and a toggling in_valid is ignored.
  - Then raise out_ready: IDLE on the next edge, and in_ready=1.
- Reset: assert rst for one edge during RUN digit 2. The next cycle shows in_ready=1, out_valid=0, busy=0, sum=0, cout=0, ovf=0. A fresh operation afterwards computes correctly.
- Parameter sweep: (16,1), (16,16) and (32,8), 1000 random add/sub operations each with random in_valid/out_ready gaps. Every result matches a behavioural model, and the latency is NDIG in every case.
